tank_input_ctrl: RTL and testbench
==================================

# tank_input_ctrl

Per-frame input controller for the player tank. Consumes the 16-bit USB keycode word exported by the Nios II system and the vertical-sync frame signal, and produces registered per-frame tank commands (heading, move enable, single-shot fire with cooldown). It sits between the keycode PIO and the tank motion/projectile logic, replacing raw keycode decoding inside the motion block.

## Interface
- FIRE_COOLDOWN, 30, frames after a fire during which new fire presses are dropped (1..255)
- Clk  input  1  system clock, 50 MHz
- Reset  input  1  asynchronous, active-high reset
- frame_clk  input  1  frame signal, same net as VGA_VS; asynchronous to Clk-domain logic, one rising edge per frame
- keycode  input  16  [7:0] key slot 0, [15:8] key slot 1; USB HID usage codes, 0x00 = no key
- frame_tick  output  1  one-Clk pulse marking a processed frame; outputs below update in the same cycle
- dir  output  2  tank heading: 00 up, 01 right, 10 down, 11 left
- move  output  1  1 = a movement key was held at the last frame tick
- fire  output  1  one-Clk pulse, coincident with frame_tick, requesting one projectile

## Operation
- Key map: W 0x1A up, D 0x07 right, S 0x16 down, A 0x04 left, Space 0x2C fire. All other codes ignored.
- Frame detection: frame_clk passes through two flops (s1, s2) then a previous-value flop (prev); internal tick = s2 & ~prev. s1, s2, prev all reset to 1, so a frame_clk already high at reset release produces no tick.
- On internal tick, outputs load on the next Clk edge:
  - movement: if slot 0 is a movement key, use it; else if slot 1 is a movement key, use it; else none. Slot 0 wins when both slots hold movement keys, including opposite directions.
  - movement found: dir = mapped heading, move = 1. None: move = 0, dir holds its previous value.
  - fire_now = Space in slot 0 or slot 1. fire = 1 when fire_now & ~space_prev & (cooldown == 0); cooldown then loads FIRE_COOLDOWN. Otherwise, if cooldown != 0, cooldown decrements by 1. space_prev <= fire_now on every tick.
  - Held Space never auto-repeats; a press arriving during cooldown is dropped, not queued. Fresh release and re-press is required after cooldown expires.
- Between ticks: dir and move hold; fire and frame_tick are 0; cooldown and space_prev hold.
- keycode is sampled only at the tick; changes between ticks are invisible.
- Cooldown counter width: $clog2(FIRE_COOLDOWN+1); saturates at 0, never wraps.

## Timing
- Reset values: frame_tick 0, dir 00, move 0, fire 0, cooldown 0, space_prev 0, s1/s2/prev 1.
- Reset asserted mid-frame clears all state immediately; the in-progress frame produces no tick.
- Latency: frame_clk rising before Clk edge E0 → s1 at E0, s2 at E1, outputs and frame_tick/fire pulses registered at E2 (visible the cycle after E2, 2-3 cycles after the asynchronous edge).
- frame_tick and fire are exactly one Clk cycle wide; at most one tick per frame_clk rising edge.
- frame_clk glitches shorter than one Clk period may be missed; none are expected from the VGA controller.
- keycode must be stable for one cycle around the tick (PIO write from software is single-cycle atomic).

## Test plan
- Reset with frame_clk held high, release, hold 20 cycles → no frame_tick; outputs remain 00/0/0.
- keycode 0x0007, one frame_clk pulse → frame_tick and dir=01, move=1 exactly 3 edges after rising edge; then keycode 0x0000, next frame → move=0, dir stays 01.
- keycode 0x1A04 (slot1 W, slot0 A) → dir=11; keycode 0x1A2C (slot0 Space, slot1 W) → dir=00, move=1, fire=1.
- FIRE_COOLDOWN=3: Space held 6 frames → fire on frame 1 only; release frame 7, press frame 8 → fire on frame 8.
- FIRE_COOLDOWN=3: press frame 1 (fire), release frame 2, press frame 3 (cooldown 2→1, dropped), release 4, press frame 5 (cooldown 0) → fire on frame 5 only.
- Assert Reset mid-frame with cooldown=2, move=1 → all outputs 0 next cycle; Space on first post-reset frame fires.

Source files
------------

// File: rtl/tank_input_ctrl_if.sv
// Keycode/frame inputs and per-frame tank command outputs of tank_input_ctrl.
// master drives keycode and frame_clk; slave is the controller itself.
interface tank_input_ctrl_if;
    logic        frame_clk;
    logic [15:0] keycode;
    logic        frame_tick;
    logic [1:0]  dir;
    logic        move;
    logic        fire;

    modport master (
        output frame_clk, keycode,
        input  frame_tick, dir, move, fire
    );

    modport slave (
        input  frame_clk, keycode,
        output frame_tick, dir, move, fire
    );
endinterface

// File: rtl/tank_input_ctrl.sv
// Per-frame player tank input controller.
// Synchronises the VGA vsync frame signal, then on each frame samples the
// keycode word once and registers heading, move enable and a cooldown-gated
// single-shot fire pulse.
module tank_input_ctrl #(
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic            Clk,
    input  logic            Reset,
    tank_input_ctrl_if.slave bus
);
    localparam int CW = $clog2(FIRE_COOLDOWN + 1);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    logic          s1, s2, prev;
    logic          tick;
    logic [CW-1:0] cooldown;
    logic          space_prev;

    logic          mv0_vld, mv1_vld, mv_vld;
    logic [1:0]    mv0_dir, mv1_dir, mv_dir;
    logic          fire_now, fire_go;

    // {valid, heading} for a movement key, valid = 0 for anything else
    function automatic logic [2:0] key_move(input logic [7:0] k);
        case (k)
            KEY_W:   return 3'b1_00;
            KEY_D:   return 3'b1_01;
            KEY_S:   return 3'b1_10;
            KEY_A:   return 3'b1_11;
            default: return 3'b0_00;
        endcase
    endfunction

    // Two-flop synchroniser plus edge history. All reset high so a frame
    // signal already high when reset releases does not look like a new frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= bus.frame_clk;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign tick = s2 & ~prev;

    // Decode both key slots; slot 0 has priority for movement, either slot fires.
    always_comb begin
        {mv0_vld, mv0_dir} = key_move(bus.keycode[7:0]);
        {mv1_vld, mv1_dir} = key_move(bus.keycode[15:8]);
        mv_vld   = mv0_vld | mv1_vld;
        mv_dir   = mv0_vld ? mv0_dir : mv1_dir;
        fire_now = (bus.keycode[7:0] == KEY_SPACE) || (bus.keycode[15:8] == KEY_SPACE);
        // fire only on a fresh press with the cooldown fully expired
        fire_go  = fire_now & ~space_prev & (cooldown == '0);
    end

    // Per-frame command registers; pulses are cleared on every non-tick cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.frame_tick <= 1'b0;
            bus.dir        <= 2'b00;
            bus.move       <= 1'b0;
            bus.fire       <= 1'b0;
            cooldown       <= '0;
            space_prev     <= 1'b0;
        end else begin
            bus.frame_tick <= tick;
            bus.fire       <= 1'b0;
            if (tick) begin
                bus.move   <= mv_vld;
                if (mv_vld)
                    bus.dir <= mv_dir;
                space_prev <= fire_now;
                if (fire_go) begin
                    bus.fire <= 1'b1;
                    cooldown <= CW'(FIRE_COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tank_input_ctrl.sv
// Bench for tank_input_ctrl: directed frames from the test plan followed by
// randomized frames, all checked every cycle against a frame-level model.
module tb_tank_input_ctrl;
    localparam int FC   = 3;
    localparam int NLIT = 17;

    // expected results of the directed frames 1..17
    localparam logic [1:0] LIT_DIR  [NLIT] = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                               2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    localparam logic       LIT_MOVE [NLIT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic       LIT_FIRE [NLIT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic Clk = 1'b0;
    logic Reset;
    int   vectors = 0;
    int   miscompares = 0;

    tank_input_ctrl_if bus();

    tank_input_ctrl #(.FIRE_COOLDOWN(FC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Frame-level model: a rising frame_clk seen at an edge produces a tick
    // two edges later using the keycode present at that moment.
    initial begin : compare
        int       pend;
        logic     last_fc;
        int       frame_idx;
        logic [1:0] m_dir;
        logic     m_move, m_sp;
        int       m_cd;
        logic     e_tick, e_fire, applied;
        logic [7:0] k0, k1;
        logic     fire_now;
        pend = 0; last_fc = 1'b1; frame_idx = 0;
        m_dir = 2'd0; m_move = 1'b0; m_sp = 1'b0; m_cd = 0;
        forever begin
            @(posedge Clk); #1;
            e_tick = 1'b0; e_fire = 1'b0; applied = 1'b0;
            if (Reset) begin
                m_dir = 2'd0; m_move = 1'b0; m_sp = 1'b0; m_cd = 0;
                pend = 0; last_fc = 1'b1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        applied = 1'b1;
                        frame_idx++;
                        e_tick = 1'b1;
                        k0 = bus.keycode[7:0];
                        k1 = bus.keycode[15:8];
                        m_move = 1'b1;
                        if      (k0 == 8'h1A) m_dir = 2'd0;
                        else if (k0 == 8'h07) m_dir = 2'd1;
                        else if (k0 == 8'h16) m_dir = 2'd2;
                        else if (k0 == 8'h04) m_dir = 2'd3;
                        else if (k1 == 8'h1A) m_dir = 2'd0;
                        else if (k1 == 8'h07) m_dir = 2'd1;
                        else if (k1 == 8'h16) m_dir = 2'd2;
                        else if (k1 == 8'h04) m_dir = 2'd3;
                        else m_move = 1'b0;
                        fire_now = (k0 == 8'h2C) || (k1 == 8'h2C);
                        if (fire_now && !m_sp && m_cd == 0) begin
                            e_fire = 1'b1;
                            m_cd = FC;
                        end else if (m_cd > 0) begin
                            m_cd--;
                        end
                        m_sp = fire_now;
                    end
                end
                if (bus.frame_clk && !last_fc) pend = 2;
                last_fc = bus.frame_clk;
            end
            chk("frame_tick", int'(bus.frame_tick), int'(e_tick));
            chk("fire", int'(bus.fire), int'(e_fire));
            chk("dir", int'(bus.dir), int'(m_dir));
            chk("move", int'(bus.move), int'(m_move));
            if (applied && frame_idx <= NLIT) begin
                chk($sformatf("lit_dir[%0d]", frame_idx), int'(bus.dir), int'(LIT_DIR[frame_idx-1]));
                chk($sformatf("lit_move[%0d]", frame_idx), int'(bus.move), int'(LIT_MOVE[frame_idx-1]));
                chk($sformatf("lit_fire[%0d]", frame_idx), int'(bus.fire), int'(LIT_FIRE[frame_idx-1]));
            end
        end
    end

    task automatic frame(input logic [15:0] kc, input int hi, input int lo, input logic scramble);
        @(negedge Clk);
        bus.keycode   = kc;
        bus.frame_clk = 1'b1;
        repeat (hi) @(negedge Clk);
        bus.frame_clk = 1'b0;
        // after the tick has been taken the keycode may change freely
        if (scramble) bus.keycode = 16'($urandom);
        repeat (lo) @(negedge Clk);
    endtask

    function automatic logic [7:0] rand_key();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h1A;
            2: return 8'h07;
            3: return 8'h16;
            4: return 8'h04;
            5, 6: return 8'h2C;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin : stim
        Reset = 1'b1;
        bus.frame_clk = 1'b1;
        bus.keycode = 16'h0000;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        // frame_clk high across reset release: no tick may follow
        repeat (20) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (5) @(negedge Clk);

        frame(16'h0007, 4, 6, 1'b1);
        frame(16'h0000, 4, 6, 1'b0);
        frame(16'h1A04, 4, 6, 1'b1);
        frame(16'h1A2C, 4, 6, 1'b0);
        for (int i = 0; i < 5; i++) frame(16'h002C, 4, 6, 1'b0);
        frame(16'h0000, 4, 6, 1'b0);
        frame(16'h002C, 4, 6, 1'b0);
        frame(16'h0000, 4, 6, 1'b0);
        frame(16'h2C00, 4, 6, 1'b0);
        frame(16'h0000, 4, 6, 1'b0);
        frame(16'h2C16, 4, 6, 1'b0);
        frame(16'h0416, 4, 6, 1'b0);

        // reset in the middle of a frame whose edge is already in the synchroniser
        @(negedge Clk);
        bus.keycode = 16'h0000;
        bus.frame_clk = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        frame(16'h002C, 4, 6, 1'b0);

        for (int i = 0; i < 250; i++) begin
            frame({rand_key(), rand_key()}, $urandom_range(3, 8), $urandom_range(4, 10),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
                Reset = 1'b0;
                repeat (4) @(negedge Clk);
            end
        end
        repeat (5) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
